draw_bitmap_blit: RTL and testbench
===================================

// Module: draw_bitmap_blit
// PURPOSE
// Parametrised bitmap blitter. On a start pulse it streams an IMG_W x IMG_H
// bitmap from a 1-cycle-latency synchronous RAM/ROM to the VGA adapter at
// origin (x0,y0). It supports a transparent key colour and clips against the
// screen edge. It serves full-screen backgrounds and sprites under the
// top-level draw FSM.
// PARAMETERS
// IMG_W     160     bitmap width in pixels (>=1)
// IMG_H     120     bitmap height in pixels (>=1)
// SCR_W     160     screen width; pixels with x >= SCR_W are not plotted
// SCR_H     120     screen height; pixels with y >= SCR_H are not plotted
// XW        8       screen x width
// YW        7       screen y width
// CW        9       colour width (3 bits per channel)
// AW        15      memory address width; ceil(log2(IMG_W*IMG_H))
// KEY_EN    0       1 = pixels equal to KEY_COL are skipped
// KEY_COL   9'h000  transparent key colour
// PORTS
// clk        in   1   clock
// resetn     in   1   synchronous, active-low reset
// start      in   1   request a blit; accepted only in IDLE
// x0         in   XW  bitmap origin x, sampled at accept
// y0         in   YW  bitmap origin y, sampled at accept
// mem_addr   out  AW  pixel address to bitmap memory (row-major, cy*IMG_W+cx)
// mem_q      in   CW  memory data; valid 1 cycle after mem_addr
// vga_x      out  XW  plot x
// vga_y      out  YW  plot y
// vga_colour out  CW  plot colour
// vga_plot   out  1   write enable to VGA adapter
// busy       out  1   high from the first address cycle to the last plot slot
// done       out  1   1-cycle pulse in the last plot slot
// BEHAVIOUR
// - Reset: FSM=IDLE; counters, mem_addr, vga_x/y/colour = 0; vga_plot, busy
//   and done = 0. Reset mid-blit aborts the blit immediately. No plot occurs
//   in the cycle after reset.
// - FSM IDLE -> RUN -> FLUSH -> IDLE.
//   - In IDLE with start=1 (cycle 0): latch x0/y0, cx=cy=0, mem_addr=0, go to RUN.
//   - In RUN, each cycle: present the address for (cx,cy) and advance cx. At
//     cx=IMG_W-1, cx wraps to 0 and cy increments. After the address for
//     (IMG_W-1, IMG_H-1) is issued, go to FLUSH.
//   - FLUSH: one cycle for the final data return, then go to IDLE.
// - The address is generated incrementally with a +1 counter; no multiplier.
//   The last address is IMG_W*IMG_H-1.
// - Pipeline: the (cx,cy,valid) tags are delayed one cycle to align with
//   mem_q. In slot n+1, vga_x=x0+cx and vga_y=y0+cy, and vga_colour=mem_q.
// - vga_plot = valid and not clipped and not (KEY_EN and mem_q==KEY_COL).
//   Coordinate and colour outputs update every slot, even when vga_plot=0.
// - Clip: the sums are computed at XW+1 / YW+1 bits. The pixel is clipped if
//   the sum >= SCR_W or >= SCR_H. There is no wrap-around onto the opposite edge.
// - Timing: first plot slot = cycle 2; last = cycle IMG_W*IMG_H+1.
//   busy=1 for cycles 1..IMG_W*IMG_H+1. done=1 only in cycle IMG_W*IMG_H+1.
// - start while busy is ignored (not queued). start in the same cycle as done
//   is ignored; it is accepted in the following IDLE cycle.
// - A 1x1 bitmap is legal: address at cycle 1, plot and done at cycle 2.
// STRUCTURE
// - Shared package vga_pkg: SCR_W, SCR_H, XW, YW, CW, colour constants
//   (BLACK=9'h000).
// - One sub-module, blit_addr_gen: holds the cx/cy/address counters,
//   wrap logic and last flag. Clip/key/pipeline logic and the FSM sit in the top.
// TESTING
// 1) IMG 4x3, KEY_EN=0, start with (10,20): 12 plots in cycles 2..13.
//    First plot (10,20)=mem[0]; last (13,22)=mem[11]; done at cycle 13 only.
// 2) KEY_EN=1, mem[5]=KEY_COL: 11 plots; slot for (11,21) has vga_plot=0.
//    Timing is unchanged.
// 3) Clip: 4x3 at (158,118): plots only at x in {158,159} and y in {118,119}
//    (4 plots). There are no plots at x=0/1 or y=0; done still at cycle 13.
// 4) start held high through a blit: exactly one blit per accept. The second
//    accept occurs the cycle after done; there are no lost or duplicate plots.
// 5) resetn=0 at cycle 6 of a blit: the next cycle has vga_plot=busy=done=0.
//    A new start then restarts at mem_addr=0.
// 6) Default 160x120 at (0,0): 19200 plots, last address 19199 at (159,119),
//    done at cycle 19201.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA-side constants and the blitter state type.
package vga_pkg;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int CW    = 9;

    localparam logic [8:0] BLACK = 9'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } blit_state_t;

    // Counter width for a range of n values; never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/blit_addr_gen.sv
// Bitmap scan counters: (cx,cy) plus a row-major address kept in step by +1.
module blit_addr_gen #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15,
    parameter int CXW   = 8,
    parameter int CYW   = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_clear,
    input  logic           i_step,
    output logic [CXW-1:0] o_cx,
    output logic [CYW-1:0] o_cy,
    output logic [AW-1:0]  o_addr,
    output logic           o_last
);
    logic [CXW-1:0] r_cx;
    logic [CYW-1:0] r_cy;
    logic [AW-1:0]  r_addr;
    logic           w_row_end;
    logic           w_last;

    assign w_row_end = (r_cx == CXW'(IMG_W - 1));
    assign w_last    = w_row_end && (r_cy == CYW'(IMG_H - 1));

    // Counters park on the final pixel until the next clear.
    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_addr <= '0;
        end else if (i_step && !w_last) begin
            r_addr <= r_addr + AW'(1);
            if (w_row_end) begin
                r_cx <= '0;
                r_cy <= r_cy + CYW'(1);
            end else begin
                r_cx <= r_cx + CXW'(1);
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_addr = r_addr;
    assign o_last = w_last;
endmodule

// File: rtl/draw_bitmap_blit.sv
// Streams a bitmap from 1-cycle-latency memory to the VGA adapter with
// screen-edge clipping and an optional transparent key colour.
module draw_bitmap_blit #(
    parameter int            IMG_W   = 160,
    parameter int            IMG_H   = 120,
    parameter int            SCR_W   = vga_pkg::SCR_W,
    parameter int            SCR_H   = vga_pkg::SCR_H,
    parameter int            XW      = vga_pkg::XW,
    parameter int            YW      = vga_pkg::YW,
    parameter int            CW      = vga_pkg::CW,
    parameter int            AW      = 15,
    parameter int            KEY_EN  = 0,
    parameter logic [CW-1:0] KEY_COL = vga_pkg::BLACK
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    output logic [AW-1:0] mem_addr,
    input  logic [CW-1:0] mem_q,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic          busy,
    output logic          done,
    output logic [1:0]    o_dbg_state
);
    import vga_pkg::*;

    localparam int CXW = cnt_w(IMG_W);
    localparam int CYW = cnt_w(IMG_H);
    localparam int XS  = XW + 1;
    localparam int YS  = YW + 1;

    blit_state_t    r_state;
    logic [XW-1:0]  r_x0;
    logic [YW-1:0]  r_y0;
    logic [CXW-1:0] r_tx;
    logic [CYW-1:0] r_ty;
    logic           r_valid;
    logic           r_busy;
    logic           r_done;

    logic [CXW-1:0] w_cx;
    logic [CYW-1:0] w_cy;
    logic [AW-1:0]  w_addr;
    logic           w_last;
    logic           w_accept;
    logic [XS-1:0]  w_sx;
    logic [YS-1:0]  w_sy;
    logic           w_clip;
    logic           w_key;

    assign w_accept = (r_state == ST_IDLE) && start;

    blit_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW),
        .CXW   (CXW),
        .CYW   (CYW)
    ) u_addr_gen (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (w_accept),
        .i_step  (r_state == ST_RUN),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    // Tags trail the address by one cycle so they line up with mem_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_RUN);
            r_tx    <= w_cx;
            r_ty    <= w_cy;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sums carry one extra bit so off-screen pixels clip instead of wrapping.
    assign w_sx   = {1'b0, r_x0} + XS'(r_tx);
    assign w_sy   = {1'b0, r_y0} + YS'(r_ty);
    assign w_clip = (w_sx >= XS'(SCR_W)) || (w_sy >= YS'(SCR_H));
    assign w_key  = (KEY_EN != 0) && (mem_q == KEY_COL);

    assign mem_addr    = w_addr;
    assign vga_x       = w_sx[XW-1:0];
    assign vga_y       = w_sy[YW-1:0];
    assign vga_colour  = r_valid ? mem_q : '0;
    assign vga_plot    = r_valid && !w_clip && !w_key;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_draw_bitmap_blit.sv
// Scoreboard bench: small keyed 4x3 blitter plus a full-size 160x120 instance.
module tb_draw_bitmap_blit;
    localparam int W1 = 4, H1 = 3, N1 = W1 * H1;
    localparam int W2 = 160, H2 = 120, N2 = W2 * H2;
    localparam int MAXC = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       resetn, resetn2, start, start2;
    logic [7:0] x0;
    logic [6:0] y0;

    logic [3:0]  mem_addr1;
    logic [8:0]  mem_q1, col1;
    logic [7:0]  vx1;
    logic [6:0]  vy1;
    logic        plot1, busy1, done1;
    logic [1:0]  dbg1;
    logic [14:0] mem_addr2;
    logic [8:0]  mem_q2, col2;
    logic [7:0]  vx2;
    logic [6:0]  vy2;
    logic        plot2, busy2, done2;
    logic [1:0]  dbg2;

    draw_bitmap_blit #(.IMG_W(W1), .IMG_H(H1), .AW(4), .KEY_EN(1), .KEY_COL(9'h000)) dut1 (
        .clk(clk), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
        .mem_addr(mem_addr1), .mem_q(mem_q1), .vga_x(vx1), .vga_y(vy1),
        .vga_colour(col1), .vga_plot(plot1), .busy(busy1), .done(done1), .o_dbg_state(dbg1));

    draw_bitmap_blit dut2 (
        .clk(clk), .resetn(resetn2), .start(start2), .x0(8'd0), .y0(7'd0),
        .mem_addr(mem_addr2), .mem_q(mem_q2), .vga_x(vx2), .vga_y(vy2),
        .vga_colour(col2), .vga_plot(plot2), .busy(busy2), .done(done2), .o_dbg_state(dbg2));

    logic [8:0] mem1 [16];
    always @(posedge clk) mem_q1 <= mem1[mem_addr1];

    function automatic logic [8:0] colour2(input int a);
        return 9'((a * 37 + a / W2) % 512);
    endfunction
    always @(posedge clk) mem_q2 <= colour2(int'(mem_addr2));

    // Scoreboard item: {cycle, x, y, colour}
    logic [55:0] exp_q[$];
    bit exp_busy [MAXC];
    bit exp_done [MAXC];
    int tests = 0, fails = 0;
    int free_at = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reference: pixel n of a blit accepted in cycle a appears in cycle a+2+n.
    task automatic model_blit(input int a, input int bx, input int by);
        for (int cy = 0; cy < H1; cy++)
            for (int cx = 0; cx < W1; cx++) begin
                int n, x, y;
                n = cy * W1 + cx;
                x = bx + cx;
                y = by + cy;
                if (x < 160 && y < 120 && mem1[n] != 9'h000)
                    exp_q.push_back({32'(a + 2 + n), 8'(x), 7'(y), mem1[n]});
            end
        for (int c = a + 1; c <= a + N1 + 1; c++) exp_busy[c] = 1'b1;
        exp_done[a + N1 + 1] = 1'b1;
    endtask

    task automatic do_blit(input int bx, input int by, input bit noise);
        int a;
        wait_cycle(free_at);
        a = cyc;
        x0 = 8'(bx);
        y0 = 7'(by);
        start = 1'b1;
        model_blit(a, bx, by);
        free_at = a + N1 + 2;
        @(negedge clk);
        while (cyc <= a + N1 + 1) begin
            start = noise && ($urandom_range(0, 2) == 0);
            x0 = 8'($urandom_range(0, 255));
            y0 = 7'($urandom_range(0, 127));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic hold_blits(input int k, input int bx, input int by);
        int a;
        wait_cycle(free_at);
        a = cyc;
        x0 = 8'(bx);
        y0 = 7'(by);
        start = 1'b1;
        for (int i = 0; i < k; i++) model_blit(a + i * (N1 + 2), bx, by);
        free_at = a + k * (N1 + 2);
        wait_cycle(a + (k - 1) * (N1 + 2) + 1);
        start = 1'b0;
    endtask

    task automatic reset_blit(input int bx, input int by);
        int a;
        logic [55:0] keep[$];
        wait_cycle(free_at);
        a = cyc;
        x0 = 8'(bx);
        y0 = 7'(by);
        start = 1'b1;
        model_blit(a, bx, by);
        @(negedge clk);
        start = 1'b0;
        wait_cycle(a + 6);
        resetn = 1'b0;
        foreach (exp_q[i]) if (int'(exp_q[i][55:24]) <= a + 6) keep.push_back(exp_q[i]);
        exp_q = keep;
        for (int c = a + 7; c <= a + N1 + 1; c++) begin
            exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0;
        end
        wait_cycle(a + 7);
        check("rst_plot", 64'(plot1), 64'd0);
        check("rst_addr", 64'(mem_addr1), 64'd0);
        resetn = 1'b1;
        free_at = a + 8;
    endtask

    // Monitor for the small instance.
    always @(negedge clk) begin
        if (mon_on && cyc < MAXC) begin
            check("busy", 64'(busy1), 64'(exp_busy[cyc]));
            check("done", 64'(done1), 64'(exp_done[cyc]));
            while (exp_q.size() > 0 && int'(exp_q[0][55:24]) < cyc) begin
                tests++;
                fails++;
                $display("FAIL plot_missing: got none expected %0h", exp_q.pop_front());
            end
            if (plot1 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL plot_unexpected @cycle %0d: got (%0d,%0d,%0h) expected none",
                             cyc, vx1, vy1, col1);
                end else begin
                    check("plot", 64'({32'(cyc), vx1, vy1, col1}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Full-size instance: row-major order, every pixel on screen.
    int b2 = -100, n2 = 0, done2_cnt = 0;
    always @(negedge clk) begin
        if (b2 >= 0) begin
            if (plot2 === 1'b1) begin
                check("plot2", 64'({32'(cyc), vx2, vy2, col2}),
                      64'({32'(b2 + 2 + n2), 8'(n2 % W2), 7'(n2 / W2), colour2(n2)}));
                n2++;
            end
            if (done2 === 1'b1) begin
                done2_cnt++;
                check("done2_cycle", 64'(cyc), 64'(b2 + N2 + 1));
            end
        end
    end

    initial begin
        wait_cycle(3);
        b2 = cyc;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_cycle(b2 + N2);
        check("last_addr2", 64'(mem_addr2), 64'(N2 - 1));
    end

    initial begin
        resetn = 1'b0;
        resetn2 = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        x0 = '0;
        y0 = '0;
        for (int i = 0; i < 16; i++) mem1[i] = 9'($urandom_range(1, 511));
        wait_cycle(2);
        @(negedge clk);
        check("rst_addr0", 64'(mem_addr1), 64'd0);
        check("rst_x", 64'(vx1), 64'd0);
        check("rst_y", 64'(vy1), 64'd0);
        check("rst_col", 64'(col1), 64'd0);
        check("rst_ctl", 64'({plot1, busy1, done1}), 64'd0);
        resetn = 1'b1;
        resetn2 = 1'b1;
        mon_on = 1'b1;
        free_at = cyc + 1;

        do_blit(10, 20, 1'b0);
        mem1[5] = 9'h000;
        do_blit(10, 20, 1'b0);
        mem1[5] = 9'h1a5;
        do_blit(158, 118, 1'b1);
        hold_blits(3, 40, 50);
        reset_blit(30, 30);
        do_blit(5, 6, 1'b0);
        for (int t = 0; t < 12; t++) begin
            int rx, ry;
            for (int i = 0; i < N1; i++)
                mem1[i] = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
            rx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
            do_blit(rx, ry, 1'b1);
        end
        wait_cycle(free_at + 3);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        wait_cycle(N2 + 100);
        check("plots2", 64'(n2), 64'(N2));
        check("done2_count", 64'(done2_cnt), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
